reg_file: RTL and testbench



---
 rtl/reg_file_if.sv | 24 ++
 rtl/reg_file.sv | 68 ++++++
 tb/tb_reg_file.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
// Register file access bus: two combinational read ports, one write port, ready flag.
interface reg_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              ready;

  modport master (
    output raddr1, raddr2, we, waddr, wdata,
    input  rdata1, rdata2, ready
  );

  modport slave (
    input  raddr1, raddr2, we, waddr, wdata,
    output rdata1, rdata2, ready
  );
endinterface

// File: rtl/reg_file.sv
// MIPS GPR file, r0 hardwired to zero, self-clearing after reset; REG_FILE_BYPASS_EN adds write-to-read bypass.
// Reads are combinational, writes land on the edge; writes are dropped (not held) until ready is high.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic       clk,
  input  logic       reset,
  reg_file_if.slave  bus
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Reset only restarts the sequencer; the walk through mem does the actual zeroing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      bus.ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          mem[clr_cnt] <= '0;
          clr_cnt      <= clr_cnt + 1'b1;
          if (clr_cnt == '1) begin
            state     <= RUN;
            bus.ready <= 1'b1;
          end
        end
        RUN: begin
          if (bus.we && (bus.waddr != '0)) begin
            mem[bus.waddr] <= bus.wdata;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  always_comb begin
    bus.rdata1 = '0;
    bus.rdata2 = '0;
    if (state == RUN) begin
      if (bus.raddr1 != '0) begin
        bus.rdata1 = mem[bus.raddr1];
      end
      if (bus.raddr2 != '0) begin
        bus.rdata2 = mem[bus.raddr2];
      end
`ifdef REG_FILE_BYPASS_EN
      // Decode sees the write-back value in the same cycle it is written.
      if (bus.we && (bus.waddr != '0)) begin
        if (bus.raddr1 == bus.waddr) begin
          bus.rdata1 = bus.wdata;
        end
        if (bus.raddr2 == bus.waddr) begin
          bus.rdata2 = bus.wdata;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; expectations follow REG_FILE_BYPASS_EN when defined.
module tb_reg_file;

  logic clk;
  logic reset;
  int   ncmp;
  int   nerr;

  reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_same;
    ncmp       = 0;
    nerr       = 0;
    reset      = 1'b1;
    bus.we     = 1'b0;
    bus.waddr  = '0;
    bus.wdata  = '0;
    bus.raddr1 = 5'd3;
    bus.raddr2 = 5'd31;

    // reset then idle clear
    tick();
    tick();
    chk("reset_ready", {31'd0, bus.ready}, 32'd0);
    chk("reset_rdata1", bus.rdata1, 32'd0);
    chk("reset_rdata2", bus.rdata2, 32'd0);
    reset = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i < 32) begin
        chk($sformatf("clr_ready_e%0d", i), {31'd0, bus.ready}, 32'd0);
        chk($sformatf("clr_rdata1_e%0d", i), bus.rdata1, 32'd0);
        chk($sformatf("clr_rdata2_e%0d", i), bus.rdata2, 32'd0);
      end
    end
    chk("clr_ready_e32", {31'd0, bus.ready}, 32'd1);
    chk("run_r3_zero", bus.rdata1, 32'd0);
    chk("run_r31_zero", bus.rdata2, 32'd0);

    // write/read r5 and r31
    bus.raddr1 = 5'd5;
    bus.raddr2 = 5'd31;
    bus.we     = 1'b1;
    bus.waddr  = 5'd5;
    bus.wdata  = 32'hDEADBEEF;
    tick();
    bus.waddr  = 5'd31;
    bus.wdata  = 32'h12345678;
    chk("wr_r5", bus.rdata1, 32'hDEADBEEF);
    tick();
    bus.we = 1'b0;
    chk("wr_r31", bus.rdata2, 32'h12345678);
    chk("wr_r5_kept", bus.rdata1, 32'hDEADBEEF);

    // r0 hardwired
    bus.raddr1 = 5'd0;
    bus.raddr2 = 5'd0;
    bus.we     = 1'b1;
    bus.waddr  = 5'd0;
    bus.wdata  = 32'hFFFFFFFF;
    #1;
    chk("r0_pre_p1", bus.rdata1, 32'd0);
    chk("r0_pre_p2", bus.rdata2, 32'd0);
    tick();
    bus.we = 1'b0;
    chk("r0_post_p1", bus.rdata1, 32'd0);
    chk("r0_post_p2", bus.rdata2, 32'd0);
    bus.raddr1 = 5'd5;
    bus.raddr2 = 5'd31;
    #1;
    chk("r0_wr_no_alias_r5", bus.rdata1, 32'hDEADBEEF);
    chk("r0_wr_no_alias_r31", bus.rdata2, 32'h12345678);

    // same-cycle read of write target
    bus.we    = 1'b1;
    bus.waddr = 5'd7;
    bus.wdata = 32'h00000001;
    tick();
    bus.wdata  = 32'hA5A5A5A5;
    bus.raddr1 = 5'd7;
    bus.raddr2 = 5'd7;
    #1;
`ifdef REG_FILE_BYPASS_EN
    exp_same = 32'hA5A5A5A5;
`else
    exp_same = 32'h00000001;
`endif
    chk("same_cyc_p1", bus.rdata1, exp_same);
    chk("same_cyc_p2", bus.rdata2, exp_same);
    tick();
    bus.we = 1'b0;
    chk("after_edge_r7", bus.rdata1, 32'hA5A5A5A5);

    // reset mid-operation, with writes attempted during reset and clear
    bus.we    = 1'b1;
    bus.waddr = 5'd9;
    bus.wdata = 32'h00000077;
    tick();
    bus.we     = 1'b0;
    bus.raddr1 = 5'd9;
    bus.raddr2 = 5'd3;
    #1;
    chk("r9_written", bus.rdata1, 32'h00000077);
    reset     = 1'b1;
    bus.we    = 1'b1;
    bus.wdata = 32'h00000099;
    tick();
    chk("midrst_ready_drop", {31'd0, bus.ready}, 32'd0);
    chk("midrst_rdata1", bus.rdata1, 32'd0);
    reset     = 1'b0;
    bus.waddr = 5'd3;
    bus.wdata = 32'h00000055;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i < 32) begin
        chk($sformatf("reclr_ready_e%0d", i), {31'd0, bus.ready}, 32'd0);
        chk($sformatf("reclr_rdata2_e%0d", i), bus.rdata2, 32'd0);
      end
    end
    chk("reclr_ready_e32", {31'd0, bus.ready}, 32'd1);
    bus.we = 1'b0;
    #1;
    chk("reclr_r9_zero", bus.rdata1, 32'd0);
    chk("reclr_r3_zero", bus.rdata2, 32'd0);
    bus.raddr1 = 5'd5;
    bus.raddr2 = 5'd7;
    #1;
    chk("reclr_r5_zero", bus.rdata1, 32'd0);
    chk("reclr_r7_zero", bus.rdata2, 32'd0);

    // file usable again after re-clear
    bus.we    = 1'b1;
    bus.waddr = 5'd5;
    bus.wdata = 32'h0BADF00D;
    tick();
    bus.we = 1'b0;
    chk("rerun_wr_r5", bus.rdata1, 32'h0BADF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
